// File: rtl/spatz_vsldu_wbuf_if.sv
// Slide-unit to VRF write-buffer bus: slide-side write request and VRF-side head entry.
`default_nettype none

interface spatz_vsldu_wbuf_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32,
  parameter int NrIds     = 4
);
  localparam int BeWidth = DataWidth / 8;
  localparam int IdWidth = (NrIds > 1) ? $clog2(NrIds) : 1;

  logic [AddrWidth-1:0] sld_waddr_i;
  logic [DataWidth-1:0] sld_wdata_i;
  logic [BeWidth-1:0]   sld_wbe_i;
  logic                 sld_we_i;
  logic [IdWidth-1:0]   sld_id_i;
  logic                 sld_wvalid_o;

  logic [AddrWidth-1:0] vrf_waddr_o;
  logic [DataWidth-1:0] vrf_wdata_o;
  logic [BeWidth-1:0]   vrf_wbe_o;
  logic                 vrf_we_o;
  logic [IdWidth-1:0]   vrf_id_o;
  logic                 vrf_wvalid_i;

  logic [NrIds-1:0]     id_pending_o;
  logic                 empty_o;
  logic                 full_o;

  modport slave (
    input  sld_waddr_i, sld_wdata_i, sld_wbe_i, sld_we_i, sld_id_i, vrf_wvalid_i,
    output sld_wvalid_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o, vrf_id_o,
    output id_pending_o, empty_o, full_o
  );

  modport master (
    output sld_waddr_i, sld_wdata_i, sld_wbe_i, sld_we_i, sld_id_i, vrf_wvalid_i,
    input  sld_wvalid_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o, vrf_id_o,
    input  id_pending_o, empty_o, full_o
  );
endinterface

`default_nettype wire

// File: rtl/spatz_vsldu_wbuf.sv
// Circular write buffer between the slide unit and the VRF, with tail merging
// and per-instruction-ID pending tracking.
`default_nettype none

module spatz_vsldu_wbuf #(
  parameter int Depth     = 2,
  parameter int NrIds     = 4,
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  spatz_vsldu_wbuf_if.slave bus
);
  localparam int BeWidth  = DataWidth / 8;
  localparam int IdWidth  = (NrIds > 1) ? $clog2(NrIds) : 1;
  localparam int PtrWidth = $clog2(Depth);
  localparam int CntWidth = $clog2(Depth + 1);
  localparam logic [CntWidth-1:0] c_DEPTH = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] c_TWO   = CntWidth'(2);
  localparam logic [PtrWidth-1:0] c_LAST  = PtrWidth'(Depth - 1);

  // Entry storage carries no reset; validity is defined purely by pointers and count.
  logic [AddrWidth-1:0] r_addr [Depth];
  logic [DataWidth-1:0] r_data [Depth];
  logic [BeWidth-1:0]   r_be   [Depth];
  logic [IdWidth-1:0]   r_id   [Depth];

  logic [PtrWidth-1:0]  r_head;
  logic [PtrWidth-1:0]  r_tail;
  logic [CntWidth-1:0]  r_cnt;
  logic [CntWidth-1:0]  r_idcnt [NrIds];

  logic [PtrWidth-1:0]  w_last;
  logic                 w_pop;
  logic                 w_nonzero;
  logic                 w_merge;
  logic                 w_alloc;

  function automatic logic [PtrWidth-1:0] f_next(input logic [PtrWidth-1:0] p);
    return (p == c_LAST) ? '0 : p + PtrWidth'(1);
  endfunction

  // Most recently allocated slot, i.e. the entry just behind the write pointer.
  assign w_last    = (r_tail == '0) ? c_LAST : r_tail - PtrWidth'(1);
  assign w_pop     = (r_cnt != '0) && bus.vrf_wvalid_i;
  assign w_nonzero = |bus.sld_wbe_i;

  // Requiring two entries keeps the head, which the VRF may be sampling, out of reach.
  assign w_merge = bus.sld_we_i && w_nonzero && (r_cnt >= c_TWO) &&
                   (r_addr[w_last] == bus.sld_waddr_i) && (r_id[w_last] == bus.sld_id_i);
  assign w_alloc = bus.sld_we_i && w_nonzero && !w_merge && ((r_cnt != c_DEPTH) || w_pop);

  assign bus.sld_wvalid_o = rst_ni && bus.sld_we_i && (!w_nonzero || w_merge || w_alloc);

  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_addr[r_tail] <= bus.sld_waddr_i;
      r_data[r_tail] <= bus.sld_wdata_i;
      r_be[r_tail]   <= bus.sld_wbe_i;
      r_id[r_tail]   <= bus.sld_id_i;
    end else if (w_merge) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (bus.sld_wbe_i[b]) r_data[w_last][8*b +: 8] <= bus.sld_wdata_i[8*b +: 8];
      end
      r_be[w_last] <= r_be[w_last] | bus.sld_wbe_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop)   r_head <= f_next(r_head);
      if (w_alloc) r_tail <= f_next(r_tail);
      case ({w_alloc, w_pop})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < NrIds; i++) begin : g_idcnt
    logic w_inc;
    logic w_dec;
    assign w_inc = w_alloc && (bus.sld_id_i == IdWidth'(i));
    assign w_dec = w_pop && (r_id[r_head] == IdWidth'(i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_idcnt[i] <= '0;
      end else begin
        case ({w_inc, w_dec})
          2'b10:   r_idcnt[i] <= r_idcnt[i] + CntWidth'(1);
          2'b01:   r_idcnt[i] <= r_idcnt[i] - CntWidth'(1);
          default: r_idcnt[i] <= r_idcnt[i];
        endcase
      end
    end

    assign bus.id_pending_o[i] = (r_idcnt[i] != '0);
  end

  assign bus.vrf_we_o    = (r_cnt != '0);
  assign bus.vrf_waddr_o = r_addr[r_head];
  assign bus.vrf_wdata_o = r_data[r_head];
  assign bus.vrf_wbe_o   = r_be[r_head];
  assign bus.vrf_id_o    = r_id[r_head];
  assign bus.empty_o     = (r_cnt == '0);
  assign bus.full_o      = (r_cnt == c_DEPTH);

endmodule

`default_nettype wire
